// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial 2-bit-slice adder sequencer.
// Holds the state encoding and the slice width.
package serial_add_ctrl_pkg;

    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa2.sv
// Combinational 2-bit full adder slice shared by the sequencer.
// Port order: Sum, Carry, A, B, Cin.
module full_adder_2bit (
    output logic [1:0] Sum,
    output logic       Carry,
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic       Cin
);

    assign {Carry, Sum} = 3'(A) + 3'(B) + 3'(Cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-cycle WIDTH-bit adder built from one 2-bit slice.
// Operands are consumed LSB first; carry is chained through a register.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = WIDTH / 2;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_width_chk
        $error("serial_add_ctrl: WIDTH must be even and >= 2");
    end

    state_e             state_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;

    logic [SLICE_W-1:0] fa_sum;
    logic               fa_co;

    full_adder_2bit u_fa (
        .Sum   (fa_sum),
        .Carry (fa_co),
        .A     (opa_q[SLICE_W-1:0]),
        .B     (opb_q[SLICE_W-1:0]),
        .Cin   (carry_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    // Slice result lands in the 2-bit lane selected by the counter.
                    for (int i = 0; i < NSLICE; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            sum_q[SLICE_W*i +: SLICE_W] <= fa_sum;
                        end
                    end
                    carry_q <= fa_co;
                    opa_q   <= opa_q >> SLICE_W;
                    opb_q   <= opb_q >> SLICE_W;
                    if (cnt_q == LAST) begin
                        cout_q  <= fa_co;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
